pack_fifo: RTL and testbench
============================

# pack_fifo

Elastic buffer directly downstream of the PHY word packer. Captures each completed packed word (data, per-lane valid, K flags, sync headers) on the packer's write strobe and presents it to the datalink-side consumer over a valid/ready stream. Flushes on link-down and flags overflow, so the packer never needs backpressure.

## Interface
- `DATA_WIDTH`, default 32: bits per lane word.
- `MAX_NUM_LANES`, default 16: lane count; sets all entry field widths.
- `DEPTH`, default 8: entries; power of two, ≥ 2.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; synchronous, active-low.
- `phy_link_up_i`  in  1  link up; low flushes the FIFO.
- `fifo_wr_i`  in  1  write strobe from the packer.
- `data_i`  in  MAX_NUM_LANES*DATA_WIDTH  packed data.
- `data_valid_i`  in  MAX_NUM_LANES  per-lane valid.
- `data_k_i`  in  4*MAX_NUM_LANES  K-symbol flags.
- `sync_header_i`  in  2*MAX_NUM_LANES  Gen3+ sync headers.
- `m_valid_o`  out  1  head entry available.
- `m_ready_i`  in  1  consumer accepts the head entry.
- `m_data_o`, `m_data_valid_o`, `m_data_k_o`, `m_sync_header_o`  out  same widths as the inputs  head entry fields.
- `level_o`  out  $clog2(DEPTH)+1  occupied entries.
- `overflow_o`  out  1  sticky: a write was dropped.

## Operation
- States: ST_IDLE and ST_RUN.
  - ST_IDLE: pointers held at 0 and all writes ignored. Moves to ST_RUN on the first cycle with `phy_link_up_i`=1.
  - ST_RUN: normal operation. Moves to ST_IDLE on any cycle with `phy_link_up_i`=0.
- Flush: the ST_RUN→ST_IDLE transition clears both pointers, the level and `overflow_o` at that edge. Any write or pop in that cycle is discarded.
- Push condition: ST_RUN && `fifo_wr_i` && |`data_valid_i`.
  - A strobe with `data_valid_i`=0 is a half-word packing cycle. It is silently ignored: not stored, not an overflow.
- Pop condition: `m_valid_o` && `m_ready_i`.
- Push is accepted if not full, or if full and a pop occurs in the same cycle.
  - A push while full with no pop is dropped and sets `overflow_o`.
  - `overflow_o` clears only on reset or flush.
- Pointers are $clog2(DEPTH)+1 bits, with the MSB as the wrap bit.
  - Empty: pointers equal.
  - Full: pointers equal except for the MSB.
  - `level_o` = wr_ptr − rd_ptr, modulo 2^(width).
- Show-ahead read: `m_*` outputs are driven from the storage entry at rd_ptr. When `m_valid_o`=0 the field outputs are don't-care, but must not be X after reset.
- Stored fields are an exact copy of the inputs. There is no reordering and no lane reversal.

## Timing
- Reset (`rst_ni`=0 at a posedge): ST_IDLE, pointers 0, `m_valid_o`=0, `level_o`=0, `overflow_o`=0. The field outputs read the zeroed storage.
- Write latency: a push at edge N makes `m_valid_o`=1 from edge N onward, i.e. visible in cycle N+1.
- Pop: head advances at the accepting edge; the next entry, if any, is valid in the following cycle. Full throughput is one entry per cycle.
- Simultaneous push and pop:
  - Non-empty: level unchanged.
  - Empty: only the push applies, because `m_valid_o` was 0.
- Reset mid-operation discards all contents, same as flush. Storage contents need no clearing beyond what guarantees non-X outputs.
- `m_ready_i` may be held high continuously. `m_valid_o` never depends combinationally on `m_ready_i`.

## Structure
- Add `pack_fifo_st_e` (ST_IDLE, ST_RUN) and a packed entry struct `pack_entry_t` {data, data_valid, data_k, sync_header} to `pcie_phy_pkg`, sized from package-level lane and width constants.
- Single module. Storage is a plain array of `pack_entry_t` with a D/Q register struct for state, pointers and the overflow flag.
- No sub-module: the storage is small and is written inline.

## Test plan
- Reset, then link up. Push entries with `data_i[31:0]`=32'h0000_0001…32'h0000_0003 and `data_valid_i`=16'hFFFF; hold `m_ready_i`=0.
  - → `level_o`=3.
  - → Head `m_data_o[31:0]`=32'h0000_0001 in the cycle after the first push.
- Packer pattern: `fifo_wr_i`=1 on two consecutive cycles with `data_valid_i`=0 then 16'hFFFF.
  - → Exactly one entry stored; `overflow_o` stays 0.
- Fill to 8 with `m_ready_i`=0, then one more push.
  - → Push dropped; `overflow_o`=1; `level_o`=8.
  - Then push and pop in the same cycle while full → push accepted, `level_o` stays 8.
- Stream 20 entries with `m_ready_i`=1 throughout.
  - → Pointer wrap occurs.
  - → Output order matches input order; `level_o` ≤ 1.
- With 5 entries queued and `overflow_o`=1, drop `phy_link_up_i` for one cycle.
  - → `level_o`=0, `m_valid_o`=0, `overflow_o`=0.
  - → Pushes ignored until link is up again.
- Assert `rst_ni`=0 mid-stream with 4 entries queued.
  - → Next cycle: `m_valid_o`=0, `level_o`=0; outputs not X.

Source files
------------

// File: rtl/pcie_phy_pkg.sv
// Shared PHY-side types: lane geometry, the packed-word entry carried through
// the pack FIFO, and the FIFO's two-state control encoding.
package pcie_phy_pkg;

    localparam int PHY_DATA_WIDTH    = 32;
    localparam int PHY_MAX_NUM_LANES = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pack_fifo_st_e;

    typedef struct packed {
        logic [PHY_MAX_NUM_LANES*PHY_DATA_WIDTH-1:0] data;
        logic [PHY_MAX_NUM_LANES-1:0]                data_valid;
        logic [4*PHY_MAX_NUM_LANES-1:0]              data_k;
        logic [2*PHY_MAX_NUM_LANES-1:0]              sync_header;
    } pack_entry_t;

endpackage

// File: rtl/pack_fifo.sv
// Elastic buffer behind the PHY word packer: stores completed packed words and
// presents them show-ahead on a valid/ready stream; flushes on link-down.
module pack_fifo
    import pcie_phy_pkg::*;
#(
    parameter int DATA_WIDTH    = PHY_DATA_WIDTH,
    parameter int MAX_NUM_LANES = PHY_MAX_NUM_LANES,
    parameter int DEPTH         = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                phy_link_up_i,
    input  logic                                fifo_wr_i,
    input  logic [MAX_NUM_LANES*DATA_WIDTH-1:0] data_i,
    input  logic [MAX_NUM_LANES-1:0]            data_valid_i,
    input  logic [4*MAX_NUM_LANES-1:0]          data_k_i,
    input  logic [2*MAX_NUM_LANES-1:0]          sync_header_i,
    output logic                                m_valid_o,
    input  logic                                m_ready_i,
    output logic [MAX_NUM_LANES*DATA_WIDTH-1:0] m_data_o,
    output logic [MAX_NUM_LANES-1:0]            m_data_valid_o,
    output logic [4*MAX_NUM_LANES-1:0]          m_data_k_o,
    output logic [2*MAX_NUM_LANES-1:0]          m_sync_header_o,
    output logic [$clog2(DEPTH):0]              level_o,
    output logic                                overflow_o
);

    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int AW    = PTR_W - 1;

    typedef struct packed {
        pack_fifo_st_e    state;
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic             overflow;
    } ctrl_t;

    ctrl_t       ctrl_q;
    ctrl_t       ctrl_d;
    pack_entry_t mem_q [DEPTH];
    pack_entry_t wr_entry;
    pack_entry_t head_entry;

    logic          running;
    logic          empty;
    logic          full;
    logic          push_req;
    logic          push_ok;
    logic          pop_fire;
    logic          drop_evt;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    assign wr_entry.data        = data_i;
    assign wr_entry.data_valid  = data_valid_i;
    assign wr_entry.data_k      = data_k_i;
    assign wr_entry.sync_header = sync_header_i;

    assign wr_addr = ctrl_q.wr_ptr[AW-1:0];
    assign rd_addr = ctrl_q.rd_ptr[AW-1:0];

    assign empty = (ctrl_q.wr_ptr == ctrl_q.rd_ptr);
    assign full  = (ctrl_q.wr_ptr[PTR_W-1] != ctrl_q.rd_ptr[PTR_W-1]) &&
                   (wr_addr == rd_addr);

    // A cycle with the link down while running is a flush: nothing else applies.
    assign running  = (ctrl_q.state == ST_RUN) && phy_link_up_i;
    // Strobes with no valid lane are half-word packing cycles and carry nothing.
    assign push_req = running && fifo_wr_i && (|data_valid_i);
    assign pop_fire = running && m_valid_o && m_ready_i;
    assign push_ok  = push_req && (!full || pop_fire);
    assign drop_evt = push_req && full && !pop_fire;

    always_comb begin
        ctrl_d = ctrl_q;
        case (ctrl_q.state)
            ST_IDLE: begin
                ctrl_d.wr_ptr   = '0;
                ctrl_d.rd_ptr   = '0;
                ctrl_d.overflow = 1'b0;
                if (phy_link_up_i) begin
                    ctrl_d.state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!phy_link_up_i) begin
                    ctrl_d.state    = ST_IDLE;
                    ctrl_d.wr_ptr   = '0;
                    ctrl_d.rd_ptr   = '0;
                    ctrl_d.overflow = 1'b0;
                end else begin
                    if (push_ok) begin
                        ctrl_d.wr_ptr = ctrl_q.wr_ptr + 1'b1;
                    end
                    if (pop_fire) begin
                        ctrl_d.rd_ptr = ctrl_q.rd_ptr + 1'b1;
                    end
                    if (drop_evt) begin
                        ctrl_d.overflow = 1'b1;
                    end
                end
            end
            default: begin
                ctrl_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    // Storage is zeroed on reset so the show-ahead outputs are never X.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst_ni) begin
                mem_q[i] <= '0;
            end else if (push_ok && (wr_addr == AW'(i))) begin
                mem_q[i] <= wr_entry;
            end
        end
    end

    assign head_entry      = mem_q[rd_addr];
    assign m_valid_o       = !empty;
    assign m_data_o        = head_entry.data;
    assign m_data_valid_o  = head_entry.data_valid;
    assign m_data_k_o      = head_entry.data_k;
    assign m_sync_header_o = head_entry.sync_header;
    assign level_o         = ctrl_q.wr_ptr - ctrl_q.rd_ptr;
    assign overflow_o      = ctrl_q.overflow;

endmodule

// File: tb/tb_pack_fifo.sv
// Scoreboard bench for pack_fifo: expected entries are queued as pushes are
// driven and compared against the head whenever the consumer accepts one.
module tb_pack_fifo;
    import pcie_phy_pkg::*;

    localparam int DW    = 32;
    localparam int NL    = 16;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int EW    = NL*DW + NL + 4*NL + 2*NL;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               link;
    logic               wr;
    logic               ready;
    logic [NL*DW-1:0]   data;
    logic [NL-1:0]      dv;
    logic [4*NL-1:0]    dk;
    logic [2*NL-1:0]    sh;
    logic               m_valid;
    logic [NL*DW-1:0]   m_data;
    logic [NL-1:0]      m_dv;
    logic [4*NL-1:0]    m_dk;
    logic [2*NL-1:0]    m_sh;
    logic [LW-1:0]      level;
    logic               ovf;

    pack_fifo #(
        .DATA_WIDTH    (DW),
        .MAX_NUM_LANES (NL),
        .DEPTH         (DEPTH)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .phy_link_up_i   (link),
        .fifo_wr_i       (wr),
        .data_i          (data),
        .data_valid_i    (dv),
        .data_k_i        (dk),
        .sync_header_i   (sh),
        .m_valid_o       (m_valid),
        .m_ready_i       (ready),
        .m_data_o        (m_data),
        .m_data_valid_o  (m_dv),
        .m_data_k_o      (m_dk),
        .m_sync_header_o (m_sh),
        .level_o         (level),
        .overflow_o      (ovf)
    );

    int checks   = 0;
    int failures = 0;
    int pop_cnt  = 0;
    logic [EW-1:0] sb_q [$];
    bit   mdl_run = 1'b0;
    bit   mdl_ovf = 1'b0;

    task automatic check_val(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [31:0] word0, input logic [NL-1:0] v);
        wr = w;
        dv = v;
        for (int l = 0; l < NL; l++) begin
            data[l*DW +: DW] = $urandom;
        end
        data[31:0] = word0;
        dk = {$urandom, $urandom};
        sh = $urandom;
    endtask

    // Apply the current inputs for one clock; model the expected effect first.
    task automatic cycle();
        logic [EW-1:0] obs;
        logic [EW-1:0] exp_e;
        obs = {m_data, m_dv, m_dk, m_sh};
        if (!rst_n) begin
            sb_q.delete();
            mdl_run = 1'b0;
            mdl_ovf = 1'b0;
        end else if (!mdl_run) begin
            if (link) mdl_run = 1'b1;
        end else if (!link) begin
            sb_q.delete();
            mdl_run = 1'b0;
            mdl_ovf = 1'b0;
        end else begin
            if (ready && sb_q.size() > 0) begin
                exp_e = sb_q.pop_front();
                check_val("pop_entry", obs, exp_e);
                $display("pop %0d word0=%08h", pop_cnt, m_data[31:0]);
                pop_cnt++;
            end
            if (wr && (|dv)) begin
                if (sb_q.size() < DEPTH) sb_q.push_back({data, dv, dk, sh});
                else mdl_ovf = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_val("level", level, sb_q.size());
        check_val("m_valid", m_valid, sb_q.size() > 0);
        check_val("overflow", ovf, mdl_ovf);
        check_val("no_x", $isunknown({m_data, m_dv, m_dk, m_sh, level}), 0);
        if (sb_q.size() > 0) begin
            check_val("head", {m_data, m_dv, m_dk, m_sh}, sb_q[0]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        link  = 1'b0;
        wr    = 1'b0;
        ready = 1'b0;
        data  = '0;
        dv    = '0;
        dk    = '0;
        sh    = '0;
        @(negedge clk);
        cycle();
        cycle();
        check_val("rst_data", {m_data, m_dv, m_dk, m_sh}, 0);

        rst_n = 1'b1;
        link  = 1'b1;
        drive(1'b0, 32'h0, '0);
        cycle();

        for (int n = 1; n <= 3; n++) begin
            drive(1'b1, n, 16'hFFFF);
            cycle();
            if (n == 1) check_val("head_first", m_data[31:0], 32'h0000_0001);
        end
        check_val("level3", level, 3);

        drive(1'b1, 32'h4, 16'h0000);
        cycle();
        drive(1'b1, 32'h4, 16'hFFFF);
        cycle();
        check_val("packer_level", level, 4);
        check_val("packer_ovf", ovf, 0);

        for (int n = 5; n <= 8; n++) begin
            drive(1'b1, n, 16'hFFFF);
            cycle();
        end
        check_val("full_level", level, 8);
        drive(1'b1, 32'h9, 16'hFFFF);
        cycle();
        check_val("drop_ovf", ovf, 1);
        check_val("drop_level", level, 8);
        ready = 1'b1;
        drive(1'b1, 32'hA, 16'hFFFF);
        cycle();
        check_val("full_pushpop_level", level, 8);

        drive(1'b0, 32'h0, '0);
        repeat (8) cycle();
        check_val("drained", level, 0);

        for (int n = 0; n < 20; n++) begin
            drive(1'b1, 32'h100 + n, 16'hFFFF);
            cycle();
            check_val("stream_level_le1", level <= 1, 1);
        end
        drive(1'b0, 32'h0, '0);
        cycle();

        ready = 1'b0;
        for (int n = 0; n < 9; n++) begin
            drive(1'b1, 32'h200 + n, 16'hFFFF);
            cycle();
        end
        ready = 1'b1;
        drive(1'b0, 32'h0, '0);
        repeat (3) cycle();
        ready = 1'b0;
        check_val("pre_flush_level", level, 5);
        check_val("pre_flush_ovf", ovf, 1);

        link = 1'b0;
        drive(1'b1, 32'h300, 16'hFFFF);
        cycle();
        check_val("flush_level", level, 0);
        check_val("flush_valid", m_valid, 0);
        check_val("flush_ovf", ovf, 0);
        link = 1'b1;
        drive(1'b1, 32'h301, 16'hFFFF);
        cycle();
        check_val("idle_push_ignored", level, 0);
        drive(1'b1, 32'h302, 16'hFFFF);
        cycle();
        check_val("relink_push", level, 1);

        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 32'h400 + n, 16'hFFFF);
            cycle();
        end
        check_val("pre_reset_level", level, 4);
        rst_n = 1'b0;
        drive(1'b1, 32'h500, 16'hFFFF);
        cycle();
        check_val("reset_valid", m_valid, 0);
        check_val("reset_level", level, 0);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, '0);
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
